// File: rtl/bank_loader_pkg.sv
// Shared constants and FSM state type for the serial bank loader.
package bank_loader_pkg;

   localparam int ADDR_W     = 2;
   localparam int DATA_W_DEF = 10;
   localparam int FRAME_LEN  = ADDR_W + DATA_W_DEF + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/frame_shifter.sv
// Frame assembly: MSB-first shift register, bit counter and running odd parity.
module frame_shifter
   import bank_loader_pkg::*;
#(
   parameter int FLEN  = FRAME_LEN,
   parameter int CNT_W = $clog2(FLEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic             sdi,
   output logic [FLEN-2:0]  payload,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             par_ok
);

   logic [FLEN-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;

   // load starts a fresh frame so no stale bits leak into the parity.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      par_d = par_q;
      if (clr) begin
         sr_d  = '0;
         cnt_d = '0;
         par_d = 1'b0;
      end else if (load) begin
         sr_d  = {{(FLEN-1){1'b0}}, sdi};
         cnt_d = CNT_W'(1);
         par_d = sdi;
      end else if (shift) begin
         sr_d  = {sr_q[FLEN-2:0], sdi};
         cnt_d = cnt_q + CNT_W'(1);
         par_d = par_q ^ sdi;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
         par_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         par_q <= par_d;
      end
   end

   // The parity bit itself only matters through the running XOR.
   assign payload = sr_q[FLEN-1:1];
   assign bit_cnt = cnt_q;
   assign par_ok  = par_q;

endmodule

// File: rtl/bank_loader.sv
// Serial bank loader: odd-parity frames select one of NBANK registers and
// load it; parity failures raise a sticky error flag.
module bank_loader
   import bank_loader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NBANK  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sdi,
   input  logic                    sdi_valid,
   output logic                    sdi_ready,
   input  logic                    abort,
   input  logic                    err_clr,
   output logic [NBANK*DATA_W-1:0] bank_q,
   output logic                    upd,
   output logic [ADDR_W-1:0]       upd_bank,
   output logic                    err,
   output state_e                  dbg_state
);

   localparam int FLEN  = ADDR_W + DATA_W + 1;
   localparam int CNT_W = $clog2(FLEN + 1);

   state_e            state_q, state_d;
   logic [FLEN-2:0]   payload;
   logic [CNT_W-1:0]  bit_cnt;
   logic              par_ok;
   logic              xfer, commit, commit_ok;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] regs_q [NBANK];
   logic [DATA_W-1:0] regs_d [NBANK];

   // Handshake: a bit moves on a rising edge where sdi_valid=1 and
   // sdi_ready=1; abort in the same cycle cancels that transfer.
   assign sdi_ready = (state_q != COMMIT);
   assign xfer      = sdi_valid && sdi_ready && !abort;
   assign commit    = (state_q == COMMIT) && !abort && rst_n;
   assign commit_ok = commit && par_ok;
   assign wr_idx    = payload[FLEN-2 -: ADDR_W];
   assign wr_data   = payload[DATA_W-1:0];

   frame_shifter #(
      .FLEN  (FLEN),
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (abort || (state_q == COMMIT)),
      .load    (xfer && (state_q == IDLE)),
      .shift   (xfer && (state_q == SHIFT)),
      .sdi     (sdi),
      .payload (payload),
      .bit_cnt (bit_cnt),
      .par_ok  (par_ok)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer) state_d = SHIFT;
         SHIFT:   if (xfer && (bit_cnt == CNT_W'(FLEN - 1))) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // bank_q shows the next-state value so a commit is visible in the COMMIT cycle.
   always_comb begin
      for (int b = 0; b < NBANK; b++) begin
         regs_d[b] = regs_q[b];
         if (commit_ok && (wr_idx == ADDR_W'(b))) regs_d[b] = wr_data;
         bank_q[b*DATA_W +: DATA_W] = regs_d[b];
      end
   end

   assign err_d = (commit && !par_ok) || (err_q && !err_clr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         for (int b = 0; b < NBANK; b++) regs_q[b] <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         for (int b = 0; b < NBANK; b++) regs_q[b] <= regs_d[b];
      end
   end

   assign upd       = commit_ok;
   assign upd_bank  = commit_ok ? wr_idx : '0;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bank_loader.sv
// Self-checking bench for bank_loader: directed scenarios plus randomized
// frames against an array-based model of the bank contents and error flag.
module tb_bank_loader;
   import bank_loader_pkg::*;

   localparam int DW = 10;
   localparam int NB = 4;

   logic            clk = 1'b0;
   logic            rst_n, sdi, sdi_valid, sdi_ready, abort, err_clr;
   logic [NB*DW-1:0] bank_q;
   logic            upd, err;
   logic [1:0]      upd_bank;
   state_e          dbg_state;

   int vecs  = 0;
   int fails = 0;
   int cyc   = 0;

   logic [DW-1:0] mb [NB];
   logic          m_err;

   bank_loader #(.DATA_W(DW), .NBANK(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sdi       (sdi),
      .sdi_valid (sdi_valid),
      .sdi_ready (sdi_ready),
      .abort     (abort),
      .err_clr   (err_clr),
      .bank_q    (bank_q),
      .upd       (upd),
      .upd_bank  (upd_bank),
      .err       (err),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not end, got %0d cycles want fewer", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- model helpers ----------------
   function automatic logic [12:0] make_frame(input logic [1:0] bk, input logic [9:0] d,
                                              input bit good);
      logic p;
      p = ^{bk, d};
      return {bk, d, (good ? ~p : p)};
   endfunction

   function automatic logic [NB*DW-1:0] exp_banks();
      logic [NB*DW-1:0] v;
      for (int b = 0; b < NB; b++) v[b*DW +: DW] = mb[b];
      return v;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) mb[b] = '0;
      m_err = 1'b0;
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         sdi_valid = 1'b0;
         sdi = 1'($urandom_range(0, 1));
         step();
      end
      sdi       = b;
      sdi_valid = 1'b1;
      for (int w = 0; w < 4 && !sdi_ready; w++) step();
      if (!sdi_ready) begin
         vecs++; fails++;
         $display("FAIL ready_timeout: got sdi_ready=%0b want 1", sdi_ready);
      end
      step();
      sdi_valid = 1'b0;
   endtask

   task automatic send_range(input logic [12:0] f, input int hi, input int lo, input int maxgap);
      for (int i = hi; i >= lo; i--) drive_bit(f[i], int'($urandom_range(0, maxgap)));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; sdi = 1'b1; sdi_valid = 1'b1; abort = 1'b0; err_clr = 1'b0;
      repeat (3) step();
      rst_n = 1'b1; sdi_valid = 1'b0;
      model_reset();
      vecs++; if (dbg_state !== IDLE) begin fails++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL rst_bank: got %h want %h", bank_q, exp_banks()); end
      vecs++; if (upd !== 1'b0) begin fails++; $display("FAIL rst_upd: got %0b want 0", upd); end
      vecs++; if (upd_bank !== 2'd0) begin fails++; $display("FAIL rst_upd_bank: got %0d want 0", upd_bank); end
      vecs++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b want 0", err); end
      vecs++; if (sdi_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b want 1", sdi_ready); end
   endtask

   task automatic test_good_frame();
      send_range(make_frame(2'd2, 10'h2A5, 1'b1), 12, 0, 0);
      mb[2] = 10'h2A5;
      vecs++; if (upd !== 1'b1) begin fails++; $display("FAIL good_upd: got %0b want 1", upd); end
      vecs++; if (upd_bank !== 2'd2) begin fails++; $display("FAIL good_upd_bank: got %0d want 2", upd_bank); end
      vecs++; if (bank_q[29:20] !== 10'h2A5) begin fails++; $display("FAIL good_bank2: got %h want 2a5", bank_q[29:20]); end
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL good_banks: got %h want %h", bank_q, exp_banks()); end
      vecs++; if (sdi_ready !== 1'b0) begin fails++; $display("FAIL good_commit_ready: got %0b want 0", sdi_ready); end
      step();
      vecs++; if (upd !== 1'b0) begin fails++; $display("FAIL good_upd_after: got %0b want 0", upd); end
      vecs++; if (err !== 1'b0) begin fails++; $display("FAIL good_err: got %0b want 0", err); end
   endtask

   task automatic test_bad_parity();
      send_range(make_frame(2'd2, 10'h2A5, 1'b0), 12, 0, 0);
      vecs++; if (upd !== 1'b0) begin fails++; $display("FAIL bad_upd: got %0b want 0", upd); end
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL bad_banks: got %h want %h", bank_q, exp_banks()); end
      step();
      m_err = 1'b1;
      vecs++; if (err !== m_err) begin fails++; $display("FAIL bad_err_set: got %0b want %0b", err, m_err); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      m_err = 1'b0;
      vecs++; if (err !== m_err) begin fails++; $display("FAIL bad_err_clr: got %0b want %0b", err, m_err); end
   endtask

   task automatic test_stall();
      logic [12:0] f;
      f = make_frame(2'd1, 10'h3FF, 1'b1);
      send_range(f, 12, 7, 0);
      for (int s = 0; s < 5; s++) begin
         sdi_valid = 1'b0;
         sdi = 1'($urandom_range(0, 1));
         #1;
         vecs++; if (sdi_ready !== 1'b1) begin fails++; $display("FAIL stall_ready: got %0b want 1", sdi_ready); end
         vecs++; if (upd !== 1'b0) begin fails++; $display("FAIL stall_upd: got %0b want 0", upd); end
         step();
      end
      send_range(f, 6, 0, 0);
      mb[1] = 10'h3FF;
      vecs++; if (upd !== 1'b1 || upd_bank !== 2'd1) begin fails++; $display("FAIL stall_upd: got %0b/%0d want 1/1", upd, upd_bank); end
      vecs++; if (bank_q[19:10] !== 10'h3FF) begin fails++; $display("FAIL stall_bank1: got %h want 3ff", bank_q[19:10]); end
      vecs++; if (sdi_ready !== 1'b0) begin fails++; $display("FAIL stall_commit_ready: got %0b want 0", sdi_ready); end
      step();
      vecs++; if (sdi_ready !== 1'b1) begin fails++; $display("FAIL stall_idle_ready: got %0b want 1", sdi_ready); end
   endtask

   task automatic test_abort();
      send_range(make_frame(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)), 1'b1), 12, 6, 0);
      sdi = 1'($urandom_range(0, 1)); sdi_valid = 1'b1; abort = 1'b1;
      step();
      abort = 1'b0; sdi_valid = 1'b0;
      vecs++; if (dbg_state !== IDLE) begin fails++; $display("FAIL abort_state: got %0d want %0d", dbg_state, IDLE); end
      send_range(make_frame(2'd0, 10'h001, 1'b1), 12, 0, 0);
      mb[0] = 10'h001;
      vecs++; if (upd !== 1'b1 || upd_bank !== 2'd0) begin fails++; $display("FAIL abort_upd: got %0b/%0d want 1/0", upd, upd_bank); end
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL abort_banks: got %h want %h", bank_q, exp_banks()); end
      step();
   endtask

   task automatic test_reset_mid();
      send_range(make_frame(2'd3, 10'h123, 1'b0), 12, 0, 0);
      step();
      send_range(make_frame(2'd3, 10'h0F0, 1'b1), 12, 4, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL rmid_banks: got %h want %h", bank_q, exp_banks()); end
      vecs++; if (err !== m_err) begin fails++; $display("FAIL rmid_err: got %0b want %0b", err, m_err); end
      vecs++; if (upd !== 1'b0 || upd_bank !== 2'd0) begin fails++; $display("FAIL rmid_upd: got %0b/%0d want 0/0", upd, upd_bank); end
      vecs++; if (dbg_state !== IDLE || sdi_ready !== 1'b1) begin fails++; $display("FAIL rmid_state: got %0d/%0b want %0d/1", dbg_state, sdi_ready, IDLE); end
      send_range(make_frame(2'd3, 10'h0F0, 1'b1), 12, 0, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL rcommit_banks: got %h want %h", bank_q, exp_banks()); end
      vecs++; if (dbg_state !== IDLE) begin fails++; $display("FAIL rcommit_state: got %0d want %0d", dbg_state, IDLE); end
   endtask

   task automatic test_back_to_back();
      int c1;
      send_range(make_frame(2'd3, 10'h155, 1'b1), 12, 0, 0);
      mb[3] = 10'h155;
      c1 = cyc;
      vecs++; if (upd !== 1'b1 || bank_q !== exp_banks()) begin fails++; $display("FAIL b2b_first: got %0b/%h want 1/%h", upd, bank_q, exp_banks()); end
      send_range(make_frame(2'd3, 10'h0AA, 1'b1), 12, 0, 0);
      mb[3] = 10'h0AA;
      vecs++; if (upd !== 1'b1 || upd_bank !== 2'd3) begin fails++; $display("FAIL b2b_second: got %0b/%0d want 1/3", upd, upd_bank); end
      vecs++; if (cyc - c1 !== 14) begin fails++; $display("FAIL b2b_spacing: got %0d want 14", cyc - c1); end
      vecs++; if (bank_q[39:30] !== 10'h0AA) begin fails++; $display("FAIL b2b_bank3: got %h want 0aa", bank_q[39:30]); end
      step();
   endtask

   task automatic test_simultaneous();
      logic [1:0] bk;
      send_range(make_frame(2'd1, 10'h2C3, 1'b0), 12, 0, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      m_err = 1'b1;
      vecs++; if (err !== m_err) begin fails++; $display("FAIL simul_err_set_wins: got %0b want %0b", err, m_err); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      m_err = 1'b0;
      bk = 2'($urandom_range(0, 3));
      send_range(make_frame(bk, 10'($urandom_range(0, 1023)), 1'b1), 12, 0, 0);
      abort = 1'b1;
      #1;
      vecs++; if (upd !== 1'b0 || upd_bank !== 2'd0) begin fails++; $display("FAIL simul_abort_upd: got %0b/%0d want 0/0", upd, upd_bank); end
      vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL simul_abort_banks: got %h want %h", bank_q, exp_banks()); end
      step();
      abort = 1'b0;
      vecs++; if (bank_q !== exp_banks() || dbg_state !== IDLE) begin fails++; $display("FAIL simul_abort_after: got %h/%0d want %h/%0d", bank_q, dbg_state, exp_banks(), IDLE); end
   endtask

   task automatic test_random();
      logic [1:0]  bk;
      logic [9:0]  d;
      logic [12:0] f;
      bit          good, clr;
      int          n;
      for (int k = 0; k < 40; k++) begin
         bk   = 2'($urandom_range(0, 3));
         d    = 10'($urandom_range(0, 1023));
         good = ($urandom_range(0, 4) != 0);
         f    = make_frame(bk, d, good);
         if ($urandom_range(0, 7) == 0) begin
            n = int'($urandom_range(1, 12));
            send_range(f, 12, 13 - n, 2);
            abort = 1'b1; sdi_valid = 1'($urandom_range(0, 1));
            step();
            abort = 1'b0; sdi_valid = 1'b0;
            vecs++; if (dbg_state !== IDLE || bank_q !== exp_banks()) begin fails++; $display("FAIL rnd_abort: got %0d/%h want %0d/%h", dbg_state, bank_q, IDLE, exp_banks()); end
         end else begin
            send_range(f, 12, 0, 2);
            clr = 1'($urandom_range(0, 1));
            err_clr = clr;
            if (good) mb[bk] = d;
            vecs++; if (upd !== good) begin fails++; $display("FAIL rnd_upd: got %0b want %0b", upd, good); end
            vecs++; if (upd_bank !== (good ? bk : 2'd0)) begin fails++; $display("FAIL rnd_upd_bank: got %0d want %0d", upd_bank, (good ? bk : 2'd0)); end
            vecs++; if (bank_q !== exp_banks()) begin fails++; $display("FAIL rnd_banks: got %h want %h", bank_q, exp_banks()); end
            m_err = !good || (m_err && !clr);
            step();
            err_clr = 1'b0;
            vecs++; if (err !== m_err) begin fails++; $display("FAIL rnd_err: got %0b want %0b", err, m_err); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_stall();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_simultaneous();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
